spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_pkg.sv | 14 +
 rtl/spi_xfer_ctrl.sv | 110 +++++++++++
 tb/tb_spi_xfer_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI transfer sequencer: default widths and 3-bit FSM encoding.
// No logic; imported by spi_xfer_ctrl.
package spi_xfer_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_COUNT_WIDTH = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// Purpose: moves TX FIFO bytes through an SPI master one at a time and pushes the replies to the RX FIFO; sticky batch-done irq only when SPI_XFER_IRQ_EN is defined.
// Latency: 5 clocks of sequencing per byte (IDLE, LOAD, START, BUSY, PUSH) plus the SPI master busy time.
// Backpressure: no byte starts while out_full is high; a received byte waits in PUSH until out_full drops (unless rx_discard).
module spi_xfer_ctrl
    import spi_xfer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   rx_discard,
    input  logic                   in_nempty,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_pop,
    input  logic                   out_full,
    output logic                   out_shift,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   spi_go,
    input  logic                   spi_state,
    output logic [DATA_WIDTH-1:0]  spi_din,
    input  logic [DATA_WIDTH-1:0]  spi_dout,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] xfer_count,
    input  logic                   irq_clear,
    output logic                   irq
);

    logic [2:0] state;
    logic       start_ok;
    logic       push_done;

    assign start_ok  = enable & in_nempty & ~out_full;
    // Leaving PUSH this cycle: either the byte is dropped or the RX FIFO has room.
    assign push_done = (state == ST_PUSH) & (rx_discard | ~out_full);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            in_pop     <= 1'b0;
            out_shift  <= 1'b0;
            spi_go     <= 1'b0;
            spi_din    <= '0;
            out_data   <= '0;
            xfer_count <= '0;
        end else begin
            in_pop    <= 1'b0;
            out_shift <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        spi_din <= in_data;
                        in_pop  <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    spi_go <= 1'b1;
                    state  <= ST_START;
                end
                ST_START: begin
                    if (spi_state) begin
                        spi_go <= 1'b0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!spi_state) begin
                        out_data <= spi_dout;
                        state    <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (push_done) begin
                        out_shift  <= ~rx_discard;
                        xfer_count <= xfer_count + COUNT_WIDTH'(1);
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    spi_go <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_XFER_IRQ_EN
    // A batch is done when a byte completes and nothing is left queued; set beats clear.
    logic irq_set;
    assign irq_set = push_done & ~in_nempty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (irq_set) begin
            irq <= 1'b1;
        end else if (irq_clear) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_clear;
    assign unused_irq_clear = irq_clear;
    assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl with TX FIFO, RX FIFO and SPI master models.
module tb_spi_xfer_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;   // narrow counter so the all-ones wrap is reachable quickly
`ifdef SPI_XFER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic          clock      = 1'b0;
    logic          reset      = 1'b0;
    logic          enable     = 1'b0;
    logic          rx_discard = 1'b0;
    logic          out_full   = 1'b0;
    logic          irq_clear  = 1'b0;
    logic          spi_state  = 1'b0;
    logic [DW-1:0] spi_dout   = '0;
    logic          in_nempty, in_pop, out_shift, spi_go, busy, irq;
    logic [DW-1:0] in_data, out_data, spi_din;
    logic [CW-1:0] xfer_count;

    always #5 clock = ~clock;

    spi_xfer_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .rx_discard(rx_discard),
        .in_nempty(in_nempty), .in_data(in_data), .in_pop(in_pop),
        .out_full(out_full), .out_shift(out_shift), .out_data(out_data),
        .spi_go(spi_go), .spi_state(spi_state), .spi_din(spi_din), .spi_dout(spi_dout),
        .busy(busy), .xfer_count(xfer_count), .irq_clear(irq_clear), .irq(irq)
    );

    // TX FIFO model: written by the stimulus, read pointer advanced by the monitor.
    logic [DW-1:0] tx_mem [64];
    int tx_wr = 0;
    int tx_rd = 0;
    assign in_nempty = (tx_wr != tx_rd);
    assign in_data   = tx_mem[tx_rd % 64];

    logic [DW-1:0] rx_mem   [256];
    logic [DW-1:0] sent_mem [256];
    logic [DW-1:0] spi_cap = '0;
    int rx_wr = 0, go_cnt = 0, pop_cnt = 0, shift_cnt = 0;
    int overlap_cnt = 0, pop_empty_cnt = 0, din_bad = 0;
    int spi_lat = 16, spi_left = 0;

    // Monitor plus SPI master model (reply = sent byte ^ 0x99 after spi_lat busy clocks).
    always @(negedge clock) begin
        if (in_pop) begin
            pop_cnt <= pop_cnt + 1;
            tx_rd   <= tx_rd + 1;
            if (!in_nempty) pop_empty_cnt <= pop_empty_cnt + 1;
            else if (spi_din !== in_data) din_bad <= din_bad + 1;
        end
        if (out_shift) begin
            rx_mem[rx_wr % 256] <= out_data;
            rx_wr     <= rx_wr + 1;
            shift_cnt <= shift_cnt + 1;
        end
        if (in_pop && out_shift) overlap_cnt <= overlap_cnt + 1;
        if (spi_left > 0) begin
            spi_left <= spi_left - 1;
            if (spi_left == 1) begin
                spi_state <= 1'b0;
                spi_dout  <= spi_cap ^ 8'h99;
            end
        end else if (spi_go && !spi_state) begin
            spi_state <= 1'b1;
            spi_cap   <= spi_din;
            spi_left  <= spi_lat;
            sent_mem[go_cnt % 256] <= spi_din;
            go_cnt    <= go_cnt + 1;
        end
    end

    typedef struct packed {
        logic [DW-1:0] din;
        logic          discard;
        logic          exp_shift;
        logic [DW-1:0] exp_rx;
    } vec_t;
    vec_t vecs [6];

    int            tests = 0;
    int            fails = 0;
    int            rx_rd = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [DW-1:0] b, input logic no_rx);
        tx_mem[tx_wr % 64] = b;
        tx_wr   = tx_wr + 1;
        exp_cnt = exp_cnt + 1'b1;
        if (!no_rx) exp_q.push_back(b ^ 8'h99);
    endtask

    task automatic wait_go(input int target, input string nm);
        int n = 0;
        while (go_cnt < target && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (go_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL %s: SPI start count %0d, expected %0d", nm, go_cnt, target);
        end
    endtask

    task automatic wait_done(input int target, input string nm);
        int n = 0;
        while (!(go_cnt >= target && !busy) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL %s: no completion, go count %0d expected %0d, busy %0b", nm, go_cnt, target, busy);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic drain_rx(input string nm);
        while (rx_rd < rx_wr) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s: got rx byte 0x%0h, expected none", nm, rx_mem[rx_rd % 256]);
            end else begin
                check(nm, rx_mem[rx_rd % 256], exp_q.pop_front());
            end
            rx_rd++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0, g0, n;
        vecs[0] = '{din: 8'h00, discard: 1'b0, exp_shift: 1'b1, exp_rx: 8'h99};
        vecs[1] = '{din: 8'hFF, discard: 1'b0, exp_shift: 1'b1, exp_rx: 8'h66};
        vecs[2] = '{din: 8'h5A, discard: 1'b0, exp_shift: 1'b1, exp_rx: 8'hC3};
        vecs[3] = '{din: 8'h12, discard: 1'b1, exp_shift: 1'b0, exp_rx: 8'h00};
        vecs[4] = '{din: 8'h81, discard: 1'b0, exp_shift: 1'b1, exp_rx: 8'h18};
        vecs[5] = '{din: 8'hC3, discard: 1'b1, exp_shift: 1'b0, exp_rx: 8'h00};

        repeat (3) @(negedge clock);
        check("rst_in_pop", in_pop, 0);
        check("rst_out_shift", out_shift, 0);
        check("rst_spi_go", spi_go, 0);
        check("rst_spi_din", spi_din, 0);
        check("rst_out_data", out_data, 0);
        check("rst_count", xfer_count, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        tick();
        reset = 1'b1;
        tick();

        // Single byte, 16 busy clocks.
        enable = 1'b1;
        g0 = go_cnt;
        push_tx(8'hA5, 1'b0);
        wait_done(g0 + 1, "a5_done");
        check("a5_pops", pop_cnt, 1);
        check("a5_spi_din", sent_mem[0], 8'hA5);
        check("a5_shifts", shift_cnt, 1);
        check("a5_out_data", out_data, 8'h3C);
        drain_rx("a5_rx");
        check("a5_count", xfer_count, exp_cnt);
        check("a5_irq", irq, IRQ_ON);
        tick(); irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        @(negedge clock);
        check("a5_irq_clear", irq, 0);

        spi_lat = 3;
        for (int i = 0; i < 6; i++) begin
            s0 = shift_cnt;
            g0 = go_cnt;
            tick();
            rx_discard = vecs[i].discard;
            push_tx(vecs[i].din, vecs[i].discard);
            wait_done(g0 + 1, $sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_shift", i), shift_cnt - s0, vecs[i].exp_shift);
            if (vecs[i].exp_shift) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_rx);
            check($sformatf("vec%0d_count", i), xfer_count, exp_cnt);
        end
        drain_rx("vec_rx");

        // Batch of 4 with rx_discard.
        tick(); irq_clear = 1'b1; tick(); irq_clear = 1'b0;
        p0 = pop_cnt; s0 = shift_cnt; g0 = go_cnt;
        rx_discard = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) push_tx(8'(8'hE0 + i), 1'b1);
        wait_done(g0 + 4, "batch_done");
        check("batch_pops", pop_cnt - p0, 4);
        check("batch_shifts", shift_cnt - s0, 0);
        check("batch_count", xfer_count, exp_cnt);
        check("batch_irq", irq, IRQ_ON);

        // RX FIFO full while the byte sits in PUSH.
        rx_discard = 1'b0;
        s0 = shift_cnt; g0 = go_cnt;
        tick();
        push_tx(8'h77, 1'b0);
        wait_go(g0 + 1, "full_go");
        tick();
        out_full = 1'b1;
        repeat (8 + 10) @(negedge clock);
        check("full_no_shift", shift_cnt - s0, 0);
        check("full_held_busy", busy, 1);
        tick();
        out_full = 1'b0;
        @(negedge clock);
        check("full_release_same", out_shift, 0);
        @(negedge clock);
        check("full_release_next", out_shift, 1);
        check("full_out_data", out_data, 8'hEE);
        @(negedge clock);
        check("full_single_pulse", out_shift, 0);
        check("full_idle", busy, 0);
        drain_rx("full_rx");
        check("full_count", xfer_count, exp_cnt);

        // Drop enable mid-byte.
        p0 = pop_cnt; s0 = shift_cnt; g0 = go_cnt;
        tick();
        push_tx(8'h10, 1'b0);
        push_tx(8'h20, 1'b0);
        wait_go(g0 + 1, "en_go");
        tick();
        enable = 1'b0;
        wait_done(g0 + 1, "en_done");
        check("en_pop_one", pop_cnt - p0, 1);
        check("en_shift_one", shift_cnt - s0, 1);
        drain_rx("en_rx");
        repeat (20) @(negedge clock);
        check("en_hold_pops", pop_cnt - p0, 1);
        check("en_hold_idle", busy, 0);
        tick();
        enable = 1'b1;
        wait_done(g0 + 2, "en_resume");
        check("en_resume_pops", pop_cnt - p0, 2);
        drain_rx("en_resume_rx");
        check("en_count", xfer_count, exp_cnt);

        // Reset while the SPI master is busy.
        spi_lat = 16;
        s0 = shift_cnt; g0 = go_cnt;
        tick();
        push_tx(8'h5C, 1'b1);
        wait_go(g0 + 1, "rst_go");
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("midrst_in_pop", in_pop, 0);
        check("midrst_out_shift", out_shift, 0);
        check("midrst_spi_go", spi_go, 0);
        check("midrst_spi_din", spi_din, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_count", xfer_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_irq", irq, 0);
        repeat (3) tick();
        reset = 1'b1;
        exp_cnt = '0;
        repeat (30) @(negedge clock);
        check("midrst_no_shift", shift_cnt - s0, 0);
        check("midrst_idle", busy, 0);
        check("midrst_count_after", xfer_count, 0);

        // Fill the counter to all-ones, then wrap with irq_clear coinciding with irq set.
        spi_lat = 1;
        rx_discard = 1'b1;
        p0 = pop_cnt; g0 = go_cnt;
        tick();
        for (int i = 0; i < 15; i++) push_tx(8'(i), 1'b1);
        wait_done(g0 + 15, "wrap_fill");
        check("wrap_pops", pop_cnt - p0, 15);
        check("wrap_all_ones", xfer_count, {CW{1'b1}});
        check("wrap_irq_set", irq, IRQ_ON);
        tick(); irq_clear = 1'b1; repeat (2) tick();
        @(negedge clock);
        check("wrap_irq_cleared", irq, 0);
        g0 = go_cnt;
        tick();
        push_tx(8'h42, 1'b1);
        n = 0;
        while (!(go_cnt > g0 && !busy) && n < 200) begin
            @(negedge clock);
            n++;
        end
        irq_clear = 1'b0;
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wrap_done: no completion, busy %0b", busy);
        end
        check("irq_set_wins", irq, IRQ_ON);
        repeat (2) @(negedge clock);
        check("wrap_zero", xfer_count, 0);
        check("irq_sticky", irq, IRQ_ON);

        check("no_pop_shift_overlap", overlap_cnt, 0);
        check("no_pop_when_empty", pop_empty_cnt, 0);
        check("spi_din_matches_head", din_bad, 0);
        check("pops_total", pop_cnt, tx_wr);
        check("rx_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
